// File: rtl/offset_ram_pkg.sv
// Shared types and helpers for the per-line offset store.
package offset_ram_pkg;

  typedef enum logic [1:0] {
    OP_INC       = 2'b00,
    OP_DEC       = 2'b01,
    OP_LOAD      = 2'b10,
    OP_CLEAR_ALL = 2'b11
  } cmd_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic AXIS_H = 1'b1;
  localparam logic AXIS_V = 1'b0;

  function automatic int pos_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/offset_bank.sv
// One offset table: single-entry INC/DEC/LOAD, per-entry clear, registered read.
module offset_bank
  import offset_ram_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int OFFSET_W = 4,
  parameter bit SATURATE = 1'b0,
  localparam int POS_W   = pos_w(LINES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  cmd_op_t             wr_op_i,
  input  logic [POS_W-1:0]    wr_pos_i,
  input  logic [OFFSET_W-1:0] wr_data_i,
  input  logic                clr_en_i,
  input  logic [POS_W-1:0]    clr_pos_i,
  input  logic [POS_W-1:0]    rd_pos_i,
  output logic [OFFSET_W-1:0] rd_data_o
);

  localparam logic [OFFSET_W-1:0] ONE = OFFSET_W'(1);
  localparam logic [OFFSET_W-1:0] MAX = '1;

  logic [OFFSET_W-1:0] table_q [LINES];
  logic [OFFSET_W-1:0] rd_q;
  logic [OFFSET_W-1:0] cur_s;
  logic [OFFSET_W-1:0] upd_s;
  logic [OFFSET_W-1:0] rd_s;

  // New value for the addressed entry
  always_comb begin
    cur_s = '0;
    upd_s = '0;
    if (int'(wr_pos_i) < LINES) begin
      cur_s = table_q[wr_pos_i];
    end else begin
      cur_s = '0;
    end
    case (wr_op_i)
      OP_INC: begin
        if ((SATURATE != 1'b0) && (cur_s == MAX)) upd_s = cur_s;
        else                                      upd_s = cur_s + ONE;
      end
      OP_DEC: begin
        if ((SATURATE != 1'b0) && (cur_s == '0)) upd_s = cur_s;
        else                                     upd_s = cur_s - ONE;
      end
      OP_LOAD: upd_s = wr_data_i;
      default: upd_s = cur_s;
    endcase
  end

  // Out-of-range read indices return zero
  always_comb begin
    rd_s = '0;
    if (int'(rd_pos_i) < LINES) rd_s = table_q[rd_pos_i];
    else                        rd_s = '0;
  end

  // Table storage; clear has priority though the top never overlaps them
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINES; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (clr_en_i && (clr_pos_i == POS_W'(i)))   table_q[i] <= '0;
        else if (wr_en_i && (wr_pos_i == POS_W'(i))) table_q[i] <= upd_s;
      end
    end
  end

  // Registered read port samples the pre-write value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= rd_s;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/offset_ram_n.sv
// Per-axis offset store: command handshake, clear-all sweep FSM and completion pulse.
module offset_ram_n
  import offset_ram_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int OFFSET_W = 4,
  parameter bit SATURATE = 1'b0,
  localparam int POS_W   = pos_w(LINES)
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic                cmd_axis,
  input  logic [POS_W-1:0]    cmd_pos,
  input  logic [OFFSET_W-1:0] cmd_data,
  input  logic [POS_W-1:0]    rd_pos_x,
  input  logic [POS_W-1:0]    rd_pos_y,
  output logic [OFFSET_W-1:0] offset_x,
  output logic [OFFSET_W-1:0] offset_y,
  output logic                busy,
  output logic                moved
);

  state_t           state_q, state_d;
  logic [POS_W-1:0] sweep_q, sweep_d;
  logic             moved_q, moved_d;
  cmd_op_t          op_s;
  logic             accept_s, pos_ok_s, wr_s, wr_x_s, wr_y_s, clr_s;

  assign op_s     = cmd_op_t'(cmd_op);
  assign accept_s = cmd_valid && (state_q == ST_IDLE);
  assign pos_ok_s = (int'(cmd_pos) < LINES);
  assign wr_s     = accept_s && (op_s != OP_CLEAR_ALL) && pos_ok_s;
  assign wr_x_s   = wr_s && (cmd_axis == AXIS_V);
  assign wr_y_s   = wr_s && (cmd_axis == AXIS_H);
  assign clr_s    = (state_q == ST_CLEAR);

  // Next state, sweep counter and completion pulse
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    moved_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_s == OP_CLEAR_ALL) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
          end else begin
            moved_d = pos_ok_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (sweep_q == POS_W'(LINES - 1)) begin
          state_d = ST_IDLE;
          sweep_d = '0;
          moved_d = 1'b1;
        end else begin
          sweep_d = sweep_q + POS_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sweep_d = '0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      moved_q <= moved_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign moved     = moved_q;

  offset_bank #(.LINES(LINES), .OFFSET_W(OFFSET_W), .SATURATE(SATURATE)) u_bank_x (
    .clk_i    (sysclk),
    .rst_i    (rst),
    .wr_en_i  (wr_x_s),
    .wr_op_i  (op_s),
    .wr_pos_i (cmd_pos),
    .wr_data_i(cmd_data),
    .clr_en_i (clr_s),
    .clr_pos_i(sweep_q),
    .rd_pos_i (rd_pos_x),
    .rd_data_o(offset_x)
  );

  offset_bank #(.LINES(LINES), .OFFSET_W(OFFSET_W), .SATURATE(SATURATE)) u_bank_y (
    .clk_i    (sysclk),
    .rst_i    (rst),
    .wr_en_i  (wr_y_s),
    .wr_op_i  (op_s),
    .wr_pos_i (cmd_pos),
    .wr_data_i(cmd_data),
    .clr_en_i (clr_s),
    .clr_pos_i(sweep_q),
    .rd_pos_i (rd_pos_y),
    .rd_data_o(offset_y)
  );

endmodule

// File: tb/tb_offset_ram_n.sv
// Directed bench: three instances (wrap, saturate, LINES=10) share stimulus; scoreboard queue of expectations.
module tb_offset_ram_n;
  import offset_ram_pkg::*;

  localparam int K_OX = 0, K_OY = 1, K_MV = 2, K_RDY = 3, K_BSY = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_axis;
  logic [3:0] cmd_pos, cmd_data, rd_pos_x, rd_pos_y;
  logic [2:0] ready_s, busy_s, moved_s;
  logic [3:0] ox_s [3];
  logic [3:0] oy_s [3];

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 sysclk = ~sysclk;

  offset_ram_n #(.LINES(16), .OFFSET_W(4), .SATURATE(1'b0)) u0 (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_s[0]),
    .cmd_op(cmd_op), .cmd_axis(cmd_axis), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
    .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .offset_x(ox_s[0]), .offset_y(oy_s[0]),
    .busy(busy_s[0]), .moved(moved_s[0]));

  offset_ram_n #(.LINES(16), .OFFSET_W(4), .SATURATE(1'b1)) u1 (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_s[1]),
    .cmd_op(cmd_op), .cmd_axis(cmd_axis), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
    .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .offset_x(ox_s[1]), .offset_y(oy_s[1]),
    .busy(busy_s[1]), .moved(moved_s[1]));

  offset_ram_n #(.LINES(10), .OFFSET_W(4), .SATURATE(1'b0)) u2 (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_s[2]),
    .cmd_op(cmd_op), .cmd_axis(cmd_axis), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
    .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .offset_x(ox_s[2]), .offset_y(oy_s[2]),
    .busy(busy_s[2]), .moved(moved_s[2]));

  function automatic logic [15:0] get_sig(input int sel);
    int i;
    i = sel / 5;
    case (sel % 5)
      K_OX:    return {12'd0, ox_s[i]};
      K_OY:    return {12'd0, oy_s[i]};
      K_MV:    return {15'd0, moved_s[i]};
      K_RDY:   return {15'd0, ready_s[i]};
      default: return {15'd0, busy_s[i]};
    endcase
  endfunction

  task automatic exp3(input string tag, input int k, input int v0, input int v1, input int v2);
    sb_q.push_back('{tag, 0 * 5 + k, 16'(v0)});
    sb_q.push_back('{tag, 1 * 5 + k, 16'(v1)});
    sb_q.push_back('{tag, 2 * 5 + k, 16'(v2)});
  endtask

  task automatic exp_reset(input string tag);
    exp3(tag, K_OX, 0, 0, 0);
    exp3(tag, K_OY, 0, 0, 0);
    exp3(tag, K_MV, 0, 0, 0);
    exp3(tag, K_RDY, 1, 1, 1);
    exp3(tag, K_BSY, 0, 0, 0);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [15:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = get_sig(e.sel);
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s u%0d sig%0d observed=%0h expected=%0h", e.tag, e.sel / 5, e.sel % 5, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    check_q();
  endtask

  task automatic send(input logic [1:0] op, input logic axis, input logic [3:0] pos, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_axis  = axis;
    cmd_pos   = pos;
    cmd_data  = data;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_axis = 1'b0; cmd_pos = 4'd0; cmd_data = 4'd0;
    rd_pos_x = 4'd0; rd_pos_y = 4'd0;
    #1 rst = 1'b1;
    #2;
    exp_reset("reset");
    check_q();
    @(posedge sysclk); @(posedge sysclk); #1;
    rst = 1'b0;

    // Three back-to-back INC on y[3]
    rd_pos_x = 4'd3; rd_pos_y = 4'd3;
    for (int i = 0; i < 3; i++) begin
      send(OP_INC, AXIS_H, 4'd3, 4'd0);
      exp3("inc_moved", K_MV, 1, 1, 1);
      exp3("inc_oy", K_OY, i, i, i);
      tick();
    end
    idle();
    exp3("inc_oy_final", K_OY, 3, 3, 3);
    exp3("inc_ox_zero", K_OX, 0, 0, 0);
    exp3("inc_moved_end", K_MV, 0, 0, 0);
    tick();

    // Wrap vs saturate at zero
    rd_pos_x = 4'd0;
    send(OP_DEC, AXIS_V, 4'd0, 4'd0);
    exp3("dec0_moved", K_MV, 1, 1, 1);
    tick();
    send(OP_INC, AXIS_V, 4'd0, 4'd0);
    exp3("dec0_ox", K_OX, 15, 0, 15);
    tick();
    idle();
    exp3("inc_wrap_ox", K_OX, 0, 1, 0);
    tick();

    // Saturate at max and at zero via LOAD
    rd_pos_x = 4'd5;
    send(OP_LOAD, AXIS_V, 4'd5, 4'd15);
    exp3("ld15_moved", K_MV, 1, 1, 1);
    tick();
    send(OP_INC, AXIS_V, 4'd5, 4'd0);
    exp3("ld15_ox", K_OX, 15, 15, 15);
    exp3("incmax_moved", K_MV, 1, 1, 1);
    tick();
    send(OP_LOAD, AXIS_V, 4'd5, 4'd0);
    exp3("incmax_ox", K_OX, 0, 15, 0);
    exp3("ld0_moved", K_MV, 1, 1, 1);
    tick();
    send(OP_DEC, AXIS_V, 4'd5, 4'd0);
    exp3("ld0_ox", K_OX, 0, 0, 0);
    exp3("decmin_moved", K_MV, 1, 1, 1);
    tick();
    idle();
    exp3("decmin_ox", K_OX, 15, 0, 15);
    tick();

    // Same-edge read/write collision on y[7]
    rd_pos_y = 4'd7;
    send(OP_LOAD, AXIS_H, 4'd7, 4'd4);
    exp3("coll_pre", K_OY, 0, 0, 0);
    tick();
    send(OP_LOAD, AXIS_H, 4'd7, 4'd9);
    exp3("coll_old", K_OY, 4, 4, 4);
    tick();
    idle();
    exp3("coll_new", K_OY, 9, 9, 9);
    tick();

    // Out-of-range position only for LINES=10
    rd_pos_x = 4'd12;
    send(OP_INC, AXIS_V, 4'd12, 4'd0);
    exp3("oor_moved", K_MV, 1, 1, 0);
    tick();
    idle();
    exp3("oor_ox", K_OX, 1, 1, 0);
    exp3("oor_moved_end", K_MV, 0, 0, 0);
    tick();

    // Populate, then CLEAR_ALL with a held command behind it
    rd_pos_x = 4'd1; rd_pos_y = 4'd2;
    send(OP_LOAD, AXIS_V, 4'd1, 4'd6);
    tick();
    send(OP_LOAD, AXIS_H, 4'd2, 4'd11);
    tick();
    idle();
    exp3("pop_ox", K_OX, 6, 6, 6);
    exp3("pop_oy", K_OY, 11, 11, 11);
    tick();
    send(OP_CLEAR_ALL, AXIS_H, 4'd3, 4'd7);
    exp3("clr_rdy0", K_RDY, 0, 0, 0);
    exp3("clr_bsy0", K_BSY, 1, 1, 1);
    exp3("clr_mv0", K_MV, 0, 0, 0);
    tick();
    send(OP_LOAD, AXIS_V, 4'd9, 4'd5);
    for (int k = 1; k <= 17; k++) begin
      exp3("clr_rdy", K_RDY, int'(k >= 16), int'(k >= 16), int'(k >= 10));
      exp3("clr_bsy", K_BSY, int'(k < 16), int'(k < 16), int'(k < 10));
      exp3("clr_mv", K_MV, int'(k >= 16), int'(k >= 16), int'(k >= 10));
      tick();
    end
    idle();
    exp3("clr_mv_end", K_MV, 0, 0, 0);
    exp3("clr_rdy_end", K_RDY, 1, 1, 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_pos_x = 4'(i);
      rd_pos_y = 4'(i);
      exp3("sweep_ox", K_OX, (i == 9) ? 5 : 0, (i == 9) ? 5 : 0, (i == 9) ? 5 : 0);
      exp3("sweep_oy", K_OY, 0, 0, 0);
      tick();
    end

    // Reset in the middle of a sweep
    rd_pos_x = 4'd9;
    exp3("pre_rst_ox", K_OX, 5, 5, 5);
    tick();
    send(OP_CLEAR_ALL, AXIS_V, 4'd0, 4'd0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    exp_reset("rst_mid_sweep");
    check_q();
    @(posedge sysclk); #1;
    rst = 1'b0;
    exp3("post_rst_ox", K_OX, 0, 0, 0);
    exp3("post_rst_rdy", K_RDY, 1, 1, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
